// File: rtl/fios_pkg.sv
// Shared types for the FIOS Montgomery multiplier and its final-reduction stages.
package fios_pkg;

    localparam int unsigned WORD_W = 17;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {COLLECT, SUB, HOLD} collector_state_t;

endpackage

// File: rtl/fios_word_sub.sv
// Combinational 17-bit subtract-with-borrow: d = a - b - borrow_in.
module fios_word_sub
    import fios_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              borrow_in,
    output logic [WORD_W-1:0] d,
    output logic              borrow_out
);

    logic [WORD_W:0] diff;

    // One guard bit catches the wrap; it is set exactly when the true difference is negative.
    assign diff       = {1'b0, a} - {1'b0, b} - (WORD_W + 1)'(borrow_in);
    assign d          = diff[WORD_W-1:0];
    assign borrow_out = diff[WORD_W];

endmodule

// File: rtl/fios_result_collector.sv
// Collects the multiplier's result words LSW first, optionally reduces T from [0,2p) to [0,p)
// with a word-serial conditional subtraction, and hands the result over with valid/ready.
module fios_result_collector
    import fios_pkg::*;
#(
    parameter int unsigned s         = 8,
    parameter bit          FINAL_SUB = 1'b1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  res_valid_i,
    input  logic [WORD_W-1:0]     res_i,
    input  logic [s*WORD_W-1:0]   p_i,
    output logic [s*WORD_W-1:0]   result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int unsigned IDX_W = (s > 1) ? $clog2(s) : 1;
    localparam int unsigned RES_W = s * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(s - 1);

    collector_state_t state_q, state_d;

    word_t            t_q [s];
    word_t            d_q [s];
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] sub_idx_q;
    logic             borrow_q;

    word_t            p_word_c;
    word_t            d_word_c;
    logic             borrow_out_c;
    logic [RES_W-1:0] t_flat_c;
    logic [RES_W-1:0] d_flat_c;
    logic             handshake_c;
    logic             accept_c;
    logic             last_word_c;
    logic             last_sub_c;
    logic             overrun_c;

    // Modulus word for the current subtraction index.
    always_comb begin
        p_word_c = '0;
        for (int j = 0; j < int'(s); j++) begin
            if (sub_idx_q == IDX_W'(j)) begin
                p_word_c = p_i[j*WORD_W +: WORD_W];
            end
        end
    end

    fios_word_sub u_word_sub (
        .a          (t_q[sub_idx_q]),
        .b          (p_word_c),
        .borrow_in  (borrow_q),
        .d          (d_word_c),
        .borrow_out (borrow_out_c)
    );

    // Flattened T and D; the top D word comes straight from the subtractor on the last SUB cycle.
    always_comb begin
        t_flat_c = '0;
        d_flat_c = '0;
        for (int j = 0; j < int'(s); j++) begin
            t_flat_c[j*WORD_W +: WORD_W] = t_q[j];
            d_flat_c[j*WORD_W +: WORD_W] = (IDX_W'(j) == LAST_IDX) ? d_word_c : d_q[j];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        handshake_c = 1'b0;
        accept_c    = 1'b0;
        overrun_c   = 1'b0;
        last_word_c = (cnt_q == LAST_IDX);
        last_sub_c  = (sub_idx_q == LAST_IDX);
        case (state_q)
            COLLECT: begin
                accept_c = res_valid_i;
            end
            SUB: begin
                overrun_c = res_valid_i;
                if (last_sub_c) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                handshake_c = result_valid_o && result_ready_i;
                accept_c    = handshake_c && res_valid_i;
                overrun_c   = res_valid_i && !handshake_c;
                if (handshake_c) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
        if (accept_c && last_word_c) begin
            state_d = FINAL_SUB ? SUB : HOLD;
        end
    end

    // Word storage needs no reset: cnt_q restarting at 0 discards any partial result.
    always_ff @(posedge clock_i) begin
        if (accept_c) begin
            t_q[cnt_q] <= res_i;
        end
        if (state_q == SUB) begin
            d_q[sub_idx_q] <= d_word_c;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q          <= '0;
            sub_idx_q      <= '0;
            borrow_q       <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            overrun_o <= overrun_c;
            busy_o    <= (state_d != COLLECT);
            if (accept_c) begin
                cnt_q     <= last_word_c ? '0 : cnt_q + IDX_W'(1);
                sub_idx_q <= '0;
                borrow_q  <= 1'b0;
            end
            if (state_q == SUB) begin
                borrow_q  <= borrow_out_c;
                sub_idx_q <= last_sub_c ? '0 : sub_idx_q + IDX_W'(1);
                if (last_sub_c) begin
                    result_o <= borrow_out_c ? t_flat_c : d_flat_c;
                end
            end
            // The first HOLD cycle presents the result; valid then stays up until the handshake.
            if (state_q == HOLD) begin
                if (!result_valid_o) begin
                    result_valid_o <= 1'b1;
                    if (!FINAL_SUB) begin
                        result_o <= t_flat_c;
                    end
                end else if (handshake_c) begin
                    result_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fios_result_collector.sv
// Randomized self-checking bench: s=2 with final subtraction and s=8 bypass, both against
// an arithmetic reference model.
module tb_fios_result_collector;
    import fios_pkg::*;

    localparam int unsigned SA = 2;
    localparam int unsigned SB = 8;
    localparam int unsigned WA = SA * WORD_W;
    localparam int unsigned WB = SB * WORD_W;

    logic clk;
    logic rst;

    logic          va, rdy_a, vala, busya, ovra;
    logic [WORD_W-1:0] ra;
    logic [WA-1:0] pa, resa;

    logic          vb, rdy_b, valb, busyb, ovrb;
    logic [WORD_W-1:0] rb;
    logic [WB-1:0] pb, resb;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt_a = 0, ovr_cnt_b = 0, drops_a = 0, drops_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic [WA-1:0] exp_a;
    logic [WB-1:0] exp_b;

    fios_result_collector #(.s(SA), .FINAL_SUB(1'b1)) dut_a (
        .clock_i(clk), .reset_i(rst), .res_valid_i(va), .res_i(ra), .p_i(pa),
        .result_o(resa), .result_valid_o(vala), .result_ready_i(rdy_a),
        .busy_o(busya), .overrun_o(ovra)
    );

    fios_result_collector #(.s(SB), .FINAL_SUB(1'b0)) dut_b (
        .clock_i(clk), .reset_i(rst), .res_valid_i(vb), .res_i(rb), .p_i(pb),
        .result_o(resb), .result_valid_o(valb), .result_ready_i(rdy_b),
        .busy_o(busyb), .overrun_o(ovrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: conditional subtraction done on whole integers.
    function automatic logic [WA-1:0] ref_a(input logic [WA-1:0] t, input logic [WA-1:0] p);
        return (t >= p) ? t - p : t;
    endfunction

    // Per-cycle compare: a presented result must stay valid and equal the model value.
    always @(negedge clk) begin
        if (ovra === 1'b1) ovr_cnt_a++;
        if (ovrb === 1'b1) ovr_cnt_b++;
        if (hold_a) begin
            chk("a_hold_valid", WB'(vala), WB'(1));
            chk("a_hold_result", WB'(resa), WB'(exp_a));
        end
        if (hold_b) begin
            chk("b_hold_valid", WB'(valb), WB'(1));
            chk("b_hold_result", resb, exp_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word_a(input logic [WORD_W-1:0] w);
        va = 1'b1; ra = w;
        tick();
        va = 1'b0;
    endtask

    task automatic send_a(input logic [WA-1:0] t, input int unsigned max_gap);
        for (int i = 0; i < int'(SA); i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_word_a(t[i*WORD_W +: WORD_W]);
        end
    endtask

    task automatic wait_a(input logic [WA-1:0] exp, input bit inject);
        int n;
        n = 0;
        if (inject) begin
            va = 1'b1; ra = WORD_W'($urandom); drops_a++;
        end
        while (vala !== 1'b1 && n < 20) begin
            tick();
            va = 1'b0;
            n++;
        end
        chk("a_latency", WB'(n), WB'(SA + 1));
        chk("a_result", WB'(resa), WB'(exp));
        exp_a  = exp;
        hold_a = 1'b1;
    endtask

    task automatic ack_a();
        rdy_a = 1'b1;
        tick();
        rdy_a  = 1'b0;
        hold_a = 1'b0;
        chk("a_ack_valid", WB'(vala), WB'(0));
    endtask

    task automatic send_b(input logic [WB-1:0] t, input int unsigned max_gap);
        for (int i = 0; i < int'(SB); i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            vb = 1'b1; rb = t[i*WORD_W +: WORD_W];
            tick();
            vb = 1'b0;
        end
    endtask

    task automatic wait_b(input logic [WB-1:0] exp, input bit inject);
        int n;
        n = 0;
        if (inject) begin
            vb = 1'b1; rb = WORD_W'($urandom); drops_b++;
        end
        while (valb !== 1'b1 && n < 20) begin
            tick();
            vb = 1'b0;
            n++;
        end
        chk("b_latency", WB'(n), WB'(1));
        chk("b_result", resb, exp);
        exp_b  = exp;
        hold_b = 1'b1;
    endtask

    task automatic ack_b();
        rdy_b = 1'b1;
        tick();
        rdy_b  = 1'b0;
        hold_b = 1'b0;
        chk("b_ack_valid", WB'(valb), WB'(0));
    endtask

    task automatic run_a(input logic [WA-1:0] t, input logic [WA-1:0] exp);
        send_a(t, 0);
        wait_a(exp, 1'b0);
        ack_a();
    endtask

    initial begin
        logic [WA-1:0] t_a, p_a;
        logic [WB-1:0] t_b;
        longint unsigned r;

        rst = 1'b1;
        va = 1'b0; ra = '0; rdy_a = 1'b0; pa = '0;
        vb = 1'b0; rb = '0; rdy_b = 1'b0; pb = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_a_valid", WB'(vala), WB'(0));
        chk("rst_a_busy", WB'(busya), WB'(0));
        chk("rst_a_overrun", WB'(ovra), WB'(0));
        chk("rst_a_result", WB'(resa), WB'(0));
        chk("rst_b_valid", WB'(valb), WB'(0));
        chk("rst_b_result", resb, WB'(0));

        // p = {1, 3} = 131075
        pa = {17'd1, 17'd3};
        chk("model_pin_ge", WB'(ref_a({17'd1, 17'd5}, pa)), WB'(34'h2));
        chk("model_pin_lt", WB'(ref_a({17'd1, 17'd1}, pa)), WB'(34'h20001));

        run_a({17'd1, 17'd5}, 34'h2);
        chk("busy_after_ack", WB'(busya), WB'(0));
        run_a({17'd1, 17'd1}, 34'h20001);
        run_a({17'd1, 17'd3}, 34'h0);

        // Borrow ripples from word 0 into word 1.
        pa = {17'd1, 17'd1};
        run_a({17'd2, 17'h00000}, 34'h1FFFF);

        // Backpressure: five dropped words, then a handshake that also takes word 0.
        pa = {17'd1, 17'd3};
        send_a({17'd1, 17'd5}, 0);
        wait_a(34'h2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            va = (i % 2 == 0);
            ra = WORD_W'($urandom);
            if (va) drops_a++;
            tick();
            va = 1'b0;
        end
        chk("bp_busy", WB'(busya), WB'(1));
        rdy_a = 1'b1; va = 1'b1; ra = 17'h0ABCD;
        tick();
        rdy_a = 1'b0; va = 1'b0; hold_a = 1'b0;
        chk("bp_ack_valid", WB'(vala), WB'(0));
        send_word_a(17'd1);
        wait_a(34'h0ABCA, 1'b0);
        ack_a();
        chk("bp_overrun_cnt", WB'(ovr_cnt_a), WB'(drops_a));

        // Reset in the middle of the subtraction.
        send_a({17'd1, 17'd5}, 0);
        tick();
        chk("mid_sub_busy", WB'(busya), WB'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_valid", WB'(vala), WB'(0));
            chk("post_rst_busy", WB'(busya), WB'(0));
            tick();
        end
        run_a({17'd1, 17'd5}, 34'h2);

        // Random T < 2p with gaps and drops during the subtraction.
        for (int k = 0; k < 200; k++) begin
            r   = {$urandom, $urandom};
            p_a = WA'((r % 64'h1_FFFF_FFFF) + 64'd1);
            r   = {$urandom, $urandom};
            t_a = WA'(r % (64'(p_a) * 64'd2));
            pa  = p_a;
            send_a(t_a, 2);
            wait_a(ref_a(t_a, p_a), $urandom_range(3, 0) == 0);
            repeat ($urandom_range(2, 0)) tick();
            ack_a();
        end
        chk("a_overrun_total", WB'(ovr_cnt_a), WB'(drops_a));

        // Bypass instance: result is the collected words, one cycle after the last.
        send_b('1, 0);
        wait_b('1, 1'b0);
        ack_b();
        send_b('0, 0);
        wait_b('0, 1'b0);
        ack_b();
        for (int k = 0; k < 1000; k++) begin
            for (int w = 0; w < int'(SB); w++) begin
                t_b[w*WORD_W +: WORD_W] = WORD_W'($urandom);
            end
            for (int w = 0; w < int'(SB); w++) begin
                pb[w*WORD_W +: WORD_W] = WORD_W'($urandom);
            end
            send_b(t_b, 3);
            wait_b(t_b, $urandom_range(7, 0) == 0);
            repeat ($urandom_range(2, 0)) tick();
            ack_b();
        end
        tick();
        chk("b_overrun_total", WB'(ovr_cnt_b), WB'(drops_b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
